// File: rtl/dev_input_ctrl_pkg.sv
// Purpose: shared types and default constants for the device input controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dev_input_ctrl_pkg;

   // Default parameter values shared by the top, the channel and the bus interface
   localparam int DEF_CHANNELS        = 4;
   localparam int DEF_WIDTH           = 32;
   localparam int DEF_DEBOUNCE_CYCLES = 50000;

   // Per-channel handshake state, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_WAIT_RELEASE = 2'd2,
      ST_ACK          = 2'd3
   } chan_state_t;

   // Width of a counter that must be able to hold the value 'cycles'
   function automatic int db_cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/dev_input_ctrl_if.sv
// Purpose: bundles the processor-side and device-side signals of the input controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; the enter_out/enter_in pair forms a four-phase level handshake.
interface dev_input_ctrl_if
   import dev_input_ctrl_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int WIDTH    = DEF_WIDTH
);

   logic [CHANNELS*WIDTH-1:0] raw_data;   // device switches, channel i at [i*WIDTH +: WIDTH]
   logic [CHANNELS-1:0]       raw_btn;    // asynchronous bouncy enter buttons
   logic [CHANNELS-1:0]       enter_out;  // processor request levels
   logic [CHANNELS*WIDTH-1:0] dev_in;     // captured data, same slicing as raw_data
   logic [CHANNELS-1:0]       enter_in;   // acknowledge levels
   logic [CHANNELS-1:0]       busy;       // channel outside IDLE

   // Processor/device side: drives stimulus, observes results
   modport master (
      output raw_data,
      output raw_btn,
      output enter_out,
      input  dev_in,
      input  enter_in,
      input  busy
   );

   // Controller side
   modport slave (
      input  raw_data,
      input  raw_btn,
      input  enter_out,
      output dev_in,
      output enter_in,
      output busy
   );

endinterface

// File: rtl/dev_input_channel.sv
// Purpose: one input channel: button synchronizer, debouncer, handshake FSM and data capture.
// Latency: capture 1 cycle after the debounced press; enter_in 1 cycle after the debounced release.
// Backpressure: enter_in holds until enter_out drops; enter_out low aborts a pending request.
module dev_input_channel
   import dev_input_ctrl_pkg::*;
#(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_data,
   input  logic             raw_btn,
   input  logic             enter_out,
   output logic [WIDTH-1:0] dev_in,
   output logic             enter_in,
   output logic             busy
);

   localparam int               CNT_W    = db_cnt_width(DEBOUNCE_CYCLES);
   // Count value reached on the last mismatching cycle before the level flips
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] db_cnt;
   logic             db_level;
   logic             db_prev;
   logic             db_rise;
   logic             db_fall;
   chan_state_t      state;

   // Two-flop synchronizer; nothing downstream ever sees raw_btn directly
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw_btn;
         sync_q2 <= sync_q1;
      end
   end

   // Debouncer: flip the level after DEBOUNCE_CYCLES consecutive mismatches, any match clears the count
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt   <= '0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
      end else begin
         db_prev <= db_level;
         if (sync_q2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt >= CNT_LAST) begin
            db_level <= sync_q2;
            db_cnt   <= '0;
         end else if (db_cnt != CNT_MAX) begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end
   end

   // Edges of the debounced level, seen by the FSM the cycle after the level flips
   always_comb begin
      db_rise = db_level & ~db_prev;
      db_fall = ~db_level & db_prev;
   end

   // Handshake FSM with registered busy/enter_in and the capture register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         enter_in <= 1'b0;
         busy     <= 1'b0;
         dev_in   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A button already held down must be released before a request can arm
               if (enter_out && !db_level) begin
                  state <= ST_WAIT_PRESS;
                  busy  <= 1'b1;
               end
            end
            ST_WAIT_PRESS: begin
               if (!enter_out) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (db_rise) begin
                  state  <= ST_WAIT_RELEASE;
                  dev_in <= raw_data;
               end
            end
            ST_WAIT_RELEASE: begin
               if (!enter_out) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (db_fall) begin
                  state    <= ST_ACK;
                  enter_in <= 1'b1;
               end
            end
            ST_ACK: begin
               // Only leaving on enter_out low forces the processor to drop its request between transfers
               if (!enter_out) begin
                  state    <= ST_IDLE;
                  enter_in <= 1'b0;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               enter_in <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dev_input_ctrl.sv
// Purpose: multi-channel device input controller, one independent channel per button/data slice.
// Latency: per channel, capture 1 cycle after debounced press, enter_in 1 cycle after debounced release.
// Backpressure: four-phase level handshake per channel; enter_in holds until enter_out drops.
module dev_input_ctrl
   import dev_input_ctrl_pkg::*;
#(
   parameter int CHANNELS        = DEF_CHANNELS,
   parameter int WIDTH           = DEF_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   dev_input_ctrl_if.slave io
);

   // One fully independent channel per slice; channels share only clk and rst
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      dev_input_channel #(
         .WIDTH           (WIDTH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .raw_data  (io.raw_data[gi*WIDTH +: WIDTH]),
         .raw_btn   (io.raw_btn[gi]),
         .enter_out (io.enter_out[gi]),
         .dev_in    (io.dev_in[gi*WIDTH +: WIDTH]),
         .enter_in  (io.enter_in[gi]),
         .busy      (io.busy[gi])
      );
   end

endmodule

// File: tb/tb_dev_input_ctrl.sv
// Purpose: directed self-checking bench for dev_input_ctrl with a short debounce window.
// Latency: n/a.
// Backpressure: n/a.
module tb_dev_input_ctrl;
   import dev_input_ctrl_pkg::*;

   localparam int CH  = 4;
   localparam int W   = 32;
   localparam int DBC = 4;

   logic clk;
   logic rst;

   dev_input_ctrl_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

   dev_input_ctrl #(
      .CHANNELS        (CH),
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DBC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   typedef struct packed {
      logic [1:0]   ch;
      logic [W-1:0] data;
   } exp_t;

   exp_t     exp_q[$];
   int       tests = 0;
   int       fails = 0;
   logic [CH-1:0] prev_ack = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [W-1:0] val);
      bus.raw_data[ch*W +: W] = val;
   endtask

   task automatic expect_ack(input int ch, input logic [W-1:0] val);
      exp_t e;
      e.ch   = 2'(ch);
      e.data = val;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack(input int ch, input int budget);
      int n;
      n = 0;
      while (bus.enter_in[ch] !== 1'b1 && n < budget) begin
         step(1);
         n++;
      end
      check($sformatf("ack_arrives_ch%0d", ch), 128'(bus.enter_in[ch]), 128'd1);
   endtask

   // Scoreboard: every rising enter_in must match the oldest pending expectation for that channel
   always @(negedge clk) begin : ack_monitor
      int idx;
      for (int i = 0; i < CH; i++) begin
         if (bus.enter_in[i] === 1'b1 && prev_ack[i] === 1'b0) begin
            idx = -1;
            for (int j = 0; j < exp_q.size(); j++)
               if (idx < 0 && int'(exp_q[j].ch) == i) idx = j;
            check($sformatf("ack_expected_ch%0d", i), 128'(idx >= 0), 128'd1);
            if (idx >= 0) begin
               check($sformatf("ack_data_ch%0d", i), 128'(bus.dev_in[i*W +: W]), 128'(exp_q[idx].data));
               exp_q.delete(idx);
            end
         end
      end
      prev_ack <= bus.enter_in;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      bus.raw_data  = '0;
      bus.raw_btn   = '0;
      bus.enter_out = '0;
      step(3);
      check("reset_dev_in",   128'(bus.dev_in),   128'd0);
      check("reset_enter_in", 128'(bus.enter_in), 128'd0);
      check("reset_busy",     128'(bus.busy),     128'd0);
      rst = 1'b0;
      step(2);

      // Button on channel 1 with no request is ignored
      set_data(1, 32'hDEAD_BEEF);
      bus.raw_btn[1] = 1'b1;
      step(12);
      check("idle_press_dev_in",   128'(bus.dev_in),   128'd0);
      check("idle_press_enter_in", 128'(bus.enter_in), 128'd0);
      check("idle_press_busy",     128'(bus.busy),     128'd0);
      bus.raw_btn[1] = 1'b0;
      step(10);

      // Clean press/release on channel 0
      set_data(0, 32'h0000_00A5);
      bus.enter_out = 4'b0001;
      expect_ack(0, 32'h0000_00A5);
      step(2);
      check("ch0_busy", 128'(bus.busy), 128'h1);
      bus.raw_btn[0] = 1'b1;
      step(10);
      bus.raw_btn[0] = 1'b0;
      set_data(0, 32'h0000_005A);
      wait_ack(0, 20);
      check("ch0_enter_in", 128'(bus.enter_in), 128'h1);
      check("ch0_dev_in", 128'(bus.dev_in[31:0]), 128'hA5);
      step(3);
      check("ch0_ack_held", 128'(bus.enter_in), 128'h1);
      bus.enter_out = 4'b0000;
      step(1);
      check("ch0_ack_drop", 128'(bus.enter_in), 128'h0);
      check("ch0_idle_busy", 128'(bus.busy), 128'h0);
      check("ch0_dev_in_hold", 128'(bus.dev_in[31:0]), 128'hA5);
      step(2);

      // Bouncy button on channel 2: toggles every 2 cycles, then stable high 6 cycles
      set_data(2, 32'h0000_0C22);
      bus.enter_out = 4'b0100;
      expect_ack(2, 32'h0000_0C22);
      step(2);
      for (int k = 0; k < 6; k++) begin
         bus.raw_btn[2] = (k % 2 == 0);
         step(2);
      end
      check("ch2_no_capture_bounce", 128'(bus.dev_in[64 +: 32]), 128'd0);
      check("ch2_busy", 128'(bus.busy), 128'h4);
      bus.raw_btn[2] = 1'b1;
      step(6);
      check("ch2_no_ack_before_release", 128'(bus.enter_in), 128'h0);
      bus.raw_btn[2] = 1'b0;
      wait_ack(2, 20);
      check("ch2_enter_in", 128'(bus.enter_in), 128'h4);
      check("ch2_dev_in", 128'(bus.dev_in[64 +: 32]), 128'h0C22);
      bus.enter_out = 4'b0000;
      step(1);
      check("ch2_ack_drop", 128'(bus.enter_in), 128'h0);
      step(2);

      // Channel 0 request aborted during WAIT_RELEASE
      set_data(0, 32'h0000_0333);
      bus.enter_out = 4'b0001;
      step(2);
      bus.raw_btn[0] = 1'b1;
      for (int n = 0; n < 20 && bus.dev_in[31:0] !== 32'h333; n++) step(1);
      check("abort_capture", 128'(bus.dev_in[31:0]), 128'h333);
      bus.enter_out = 4'b0000;
      step(1);
      check("abort_busy", 128'(bus.busy), 128'h0);
      check("abort_enter_in", 128'(bus.enter_in), 128'h0);
      set_data(0, 32'h0000_0444);
      bus.raw_btn[0] = 1'b0;
      step(12);
      check("abort_no_ack", 128'(bus.enter_in), 128'h0);
      check("abort_dev_in_hold", 128'(bus.dev_in[31:0]), 128'h333);

      // Channels 0 and 3 together with overlapping presses
      set_data(0, 32'h1111_1111);
      set_data(3, 32'hFFFF_0000);
      bus.enter_out = 4'b1001;
      expect_ack(0, 32'h1111_1111);
      expect_ack(3, 32'hFFFF_0000);
      step(2);
      bus.raw_btn[0] = 1'b1;
      step(3);
      bus.raw_btn[3] = 1'b1;
      step(8);
      bus.raw_btn[0] = 1'b0;
      step(3);
      bus.raw_btn[3] = 1'b0;
      for (int n = 0; n < 30 && bus.enter_in !== 4'b1001; n++) step(1);
      check("dual_enter_in", 128'(bus.enter_in), 128'h9);
      check("dual_dev_in_ch0", 128'(bus.dev_in[31:0]), 128'h1111_1111);
      check("dual_dev_in_ch3", 128'(bus.dev_in[96 +: 32]), 128'hFFFF_0000);
      bus.enter_out = 4'b1000;
      step(1);
      check("dual_drop_ch0_only", 128'(bus.enter_in), 128'h8);
      bus.enter_out = 4'b0000;
      step(1);
      check("dual_drop_all", 128'(bus.enter_in), 128'h0);
      step(2);

      // Reset while channel 1 sits in ACK
      set_data(1, 32'hCAFE_0001);
      bus.enter_out = 4'b0010;
      expect_ack(1, 32'hCAFE_0001);
      step(2);
      bus.raw_btn[1] = 1'b1;
      step(8);
      bus.raw_btn[1] = 1'b0;
      wait_ack(1, 20);
      check("ch1_ack_busy", 128'(bus.busy), 128'h2);
      rst = 1'b1;
      bus.enter_out = 4'b0000;
      step(1);
      check("midack_rst_enter_in", 128'(bus.enter_in), 128'h0);
      check("midack_rst_dev_in",   128'(bus.dev_in),   128'd0);
      check("midack_rst_busy",     128'(bus.busy),     128'h0);
      rst = 1'b0;
      step(10);
      check("post_rst_no_ack", 128'(bus.enter_in), 128'h0);

      check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
